// File: rtl/lcd_pkg.sv
// Shared command bytes, buffer fill character and sequencing-state encoding
// for the character-LCD refresh controller.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;
  localparam logic [7:0] LCD_SPACE    = 8'h20;

  typedef enum logic [3:0] {
    PWR_WAIT,
    FUNC_SET,
    DISP_ON,
    ENTRY,
    CLEAR,
    LINE1,
    CHAR1,
    LINE2,
    CHAR2
  } lcd_state_e;

endpackage

// File: rtl/lcd_byte_tx.sv
// One-byte LCD strobe timer: setup cycle, PULSE_CYC cycles of lcd_e high, then the settle wait.
// Outputs registered, valid the cycle after start; done flags the last wait cycle; no backpressure.
module lcd_byte_tx
  import lcd_pkg::*;
#(
  parameter int unsigned PULSE_CYC = 50,
  parameter int unsigned CMD_CYC   = 5000,
  parameter int unsigned CLR_CYC   = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  output logic       done
);

  logic        busy;
  logic        long_q;
  logic [31:0] cnt;
  logic [31:0] last_cnt;

  // cnt 0 is the setup cycle; the transfer ends on cnt == PULSE_CYC + wait
  assign last_cnt = long_q ? (PULSE_CYC + CLR_CYC) : (PULSE_CYC + CMD_CYC);
  assign done     = busy && (cnt == last_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= 1'b0;
      long_q   <= 1'b0;
      cnt      <= '0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else if (start) begin
      busy     <= 1'b1;
      long_q   <= long_wait;
      cnt      <= '0;
      lcd_e    <= 1'b0;
      lcd_rs   <= rs;
      lcd_data <= data;
    end else if (busy) begin
      if (done) begin
        busy <= 1'b0;
      end else begin
        cnt   <= cnt + 32'd1;
        lcd_e <= ((cnt + 32'd1) <= PULSE_CYC);
      end
    end
  end

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// LCD init sequence then endless two-line refresh from a 32-char buffer the core may write anytime.
// Power-up wait PWR_CYC cycles, then back-to-back byte transfers; writes never stall.
module lcd_refresh_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned PULSE_CYC = 50,
  parameter int unsigned CMD_CYC   = 5000,
  parameter int unsigned CLR_CYC   = 200000,
  parameter int unsigned PWR_CYC   = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_wr_en,
  input  logic [4:0] i_wr_addr,
  input  logic [7:0] i_wr_data,
  input  logic       i_clr,
  output logic       o_ready,
  output logic [7:0] lcd_data,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw
);

  lcd_state_e        state;
  lcd_state_e        nxt_state;
  logic [3:0]        idx;
  logic [3:0]        nxt_idx;
  logic [31:0]       pwr_cnt;
  logic [31:0][7:0]  char_buf;

  logic              tx_start;
  logic              tx_rs;
  logic [7:0]        tx_data;
  logic              tx_long;
  logic              tx_done;
  logic [4:0]        rd_addr;
  logic [7:0]        rd_char;

  assign lcd_rw = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      char_buf <= {32{LCD_SPACE}};
    end else if (i_clr) begin
      char_buf <= {32{LCD_SPACE}};
    end else if (i_wr_en) begin
      char_buf[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= PWR_WAIT;
      idx     <= '0;
      pwr_cnt <= '0;
      o_ready <= 1'b0;
    end else begin
      state <= nxt_state;
      idx   <= nxt_idx;
      if (state == PWR_WAIT && !tx_start) begin
        pwr_cnt <= pwr_cnt + 32'd1;
      end
      if (tx_start && nxt_state == LINE1) begin
        o_ready <= 1'b1;
      end
    end
  end

  // state names the byte currently on the bus; a new byte is chosen in the last wait cycle
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    tx_start  = 1'b0;
    if (state == PWR_WAIT) begin
      if (pwr_cnt == PWR_CYC - 1) begin
        tx_start  = 1'b1;
        nxt_state = FUNC_SET;
      end
    end else if (tx_done) begin
      tx_start = 1'b1;
      case (state)
        FUNC_SET: nxt_state = DISP_ON;
        DISP_ON:  nxt_state = ENTRY;
        ENTRY:    nxt_state = CLEAR;
        CLEAR:    nxt_state = LINE1;
        LINE1: begin
          nxt_state = CHAR1;
          nxt_idx   = '0;
        end
        CHAR1: begin
          if (idx == 4'd15) nxt_state = LINE2;
          else              nxt_idx   = idx + 4'd1;
        end
        LINE2: begin
          nxt_state = CHAR2;
          nxt_idx   = '0;
        end
        CHAR2: begin
          if (idx == 4'd15) nxt_state = LINE1;
          else              nxt_idx   = idx + 4'd1;
        end
        default: nxt_state = PWR_WAIT;
      endcase
    end
  end

  // Forward a same-edge clear/write so the byte reflects the buffer as it stands in the setup cycle
  always_comb begin
    rd_addr = {(nxt_state == CHAR2), nxt_idx};
    if (i_clr)                                 rd_char = LCD_SPACE;
    else if (i_wr_en && i_wr_addr == rd_addr)  rd_char = i_wr_data;
    else                                       rd_char = char_buf[rd_addr];

    tx_rs   = 1'b0;
    tx_data = 8'h00;
    tx_long = (nxt_state == CLEAR);
    case (nxt_state)
      FUNC_SET:     tx_data = LCD_FUNC_SET;
      DISP_ON:      tx_data = LCD_DISP_ON;
      ENTRY:        tx_data = LCD_ENTRY;
      CLEAR:        tx_data = LCD_CLEAR;
      LINE1:        tx_data = LCD_LINE1;
      LINE2:        tx_data = LCD_LINE2;
      CHAR1, CHAR2: begin
        tx_rs   = 1'b1;
        tx_data = rd_char;
      end
      default:      tx_data = 8'h00;
    endcase
  end

  lcd_byte_tx #(
    .PULSE_CYC (PULSE_CYC),
    .CMD_CYC   (CMD_CYC),
    .CLR_CYC   (CLR_CYC)
  ) u_byte_tx (
    .clk       (clk),
    .rst       (rst),
    .start     (tx_start),
    .rs        (tx_rs),
    .data      (tx_data),
    .long_wait (tx_long),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_data  (lcd_data),
    .done      (tx_done)
  );

endmodule
